// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: NUM_LANES-wide RV32I control decode held in one pipeline register (optional DECODE_ILLEGAL_TRAP_EN).
// Latency 1 cycle from accept to out_*, 1 bundle/cycle sustained while out_ready=1.
// Backpressure: in_ready drops while a held bundle waits on out_ready or while halted; out_* hold stable.
module decode_ctrl_stage #(
   parameter int NUM_LANES = 1,
   parameter int XLEN      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_LANES-1:0]      in_lane_mask,
   input  logic [32*NUM_LANES-1:0]   in_instr,
   input  logic [XLEN-1:0]           in_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_LANES-1:0]      out_lane_mask,
   output logic [XLEN-1:0]           out_pc,
   output logic [NUM_LANES-1:0]      out_reg_write,
   output logic [NUM_LANES-1:0]      out_mem_read,
   output logic [NUM_LANES-1:0]      out_mem_write,
   output logic [NUM_LANES-1:0]      out_mem_to_reg,
   output logic [NUM_LANES-1:0]      out_branch,
   output logic [NUM_LANES-1:0]      out_jump,
   output logic [4*NUM_LANES-1:0]    out_imm_sel,
   output logic [XLEN*NUM_LANES-1:0] out_imm,
   output logic [NUM_LANES-1:0]      out_illegal
);

   localparam logic [3:0] SEL_REG   = 4'd0;
   localparam logic [3:0] SEL_I     = 4'd1;
   localparam logic [3:0] SEL_SHAMT = 4'd2;
   localparam logic [3:0] SEL_S     = 4'd3;
   localparam logic [3:0] SEL_B     = 4'd4;
   localparam logic [3:0] SEL_U     = 4'd5;
   localparam logic [3:0] SEL_J     = 4'd6;

   typedef struct packed {
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            branch;
      logic            jump;
      logic [3:0]      sel;
      logic [XLEN-1:0] imm;
   } dec_t;

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t state;

   // Decode one instruction; illegal encodings come back all-zero with ill set.
   function automatic void decode_lane(input logic [31:0] ins, output dec_t d, output logic ill);
      logic [2:0] f3;
      logic [6:0] f7;
      f3  = ins[14:12];
      f7  = ins[31:25];
      d   = '0;
      ill = 1'b0;
      case (ins[6:0])
         7'b0110011: begin
            d.reg_write = 1'b1;
            d.sel       = SEL_REG;
         end
         7'b0010011: begin
            d.reg_write = 1'b1;
            if (f3 == 3'b001) begin
               d.sel = SEL_SHAMT;
               ill   = (f7 != 7'b0000000);
            end else if (f3 == 3'b101) begin
               d.sel = SEL_SHAMT;
               ill   = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end else begin
               d.sel = SEL_I;
            end
         end
         7'b0000011: begin
            d.reg_write  = 1'b1;
            d.mem_read   = 1'b1;
            d.mem_to_reg = 1'b1;
            d.sel        = SEL_I;
            ill          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         7'b0100011: begin
            d.mem_write = 1'b1;
            d.sel       = SEL_S;
            ill         = (f3 >= 3'b011);
         end
         7'b1100011: begin
            d.branch = 1'b1;
            d.sel    = SEL_B;
            ill      = (f3 == 3'b010) || (f3 == 3'b011);
         end
         7'b1101111: begin
            d.reg_write = 1'b1;
            d.jump      = 1'b1;
            d.sel       = SEL_J;
         end
         7'b1100111: begin
            d.reg_write = 1'b1;
            d.jump      = 1'b1;
            d.sel       = SEL_I;
            ill         = (f3 != 3'b000);
         end
         7'b0110111, 7'b0010111: begin
            d.reg_write = 1'b1;
            d.sel       = SEL_U;
         end
         default: ill = 1'b1;
      endcase
      case (d.sel)
         SEL_I:     d.imm = XLEN'($signed(ins[31:20]));
         SEL_SHAMT: d.imm = XLEN'(ins[24:20]);
         SEL_S:     d.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
         SEL_B:     d.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         SEL_U:     d.imm = XLEN'($signed({ins[31:12], 12'h000}));
         SEL_J:     d.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         default:   d.imm = '0;
      endcase
      if (ill) d = '0;
   endfunction

   logic [NUM_LANES-1:0]      nxt_mask, nxt_rw, nxt_mr, nxt_mw, nxt_m2r, nxt_br, nxt_j;
   logic [4*NUM_LANES-1:0]    nxt_sel;
   logic [XLEN*NUM_LANES-1:0] nxt_imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic [NUM_LANES-1:0]      nxt_ill;
`endif
   logic                      accept;

   // Per-lane decode of the offered bundle; masked-off and illegal lanes decode to zero.
   always_comb begin
      dec_t d;
      logic ill;
`ifdef DECODE_ILLEGAL_TRAP_EN
      logic seen;
      seen    = 1'b0;
      nxt_ill = '0;
`endif
      d        = '0;
      ill      = 1'b0;
      nxt_mask = '0;
      nxt_rw   = '0;
      nxt_mr   = '0;
      nxt_mw   = '0;
      nxt_m2r  = '0;
      nxt_br   = '0;
      nxt_j    = '0;
      nxt_sel  = '0;
      nxt_imm  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         decode_lane(in_instr[32*k +: 32], d, ill);
         if (!in_lane_mask[k] || ill) d = '0;
         nxt_rw[k]  = d.reg_write;
         nxt_mr[k]  = d.mem_read;
         nxt_mw[k]  = d.mem_write;
         nxt_m2r[k] = d.mem_to_reg;
         nxt_br[k]  = d.branch;
         nxt_j[k]   = d.jump;
         nxt_sel[4*k +: 4]       = d.sel;
         nxt_imm[XLEN*k +: XLEN] = d.imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
         // The first illegal lane stays visible; everything younger is killed.
         nxt_ill[k]  = in_lane_mask[k] && ill;
         nxt_mask[k] = in_lane_mask[k] && !seen;
         seen        = seen || nxt_ill[k];
`else
         nxt_mask[k] = in_lane_mask[k];
`endif
      end
   end

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Pipeline register plus RUN/HALT control; flush outranks any accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= RUN;
         out_valid      <= 1'b0;
         out_lane_mask  <= '0;
         out_pc         <= '0;
         out_reg_write  <= '0;
         out_mem_read   <= '0;
         out_mem_write  <= '0;
         out_mem_to_reg <= '0;
         out_branch     <= '0;
         out_jump       <= '0;
         out_imm_sel    <= '0;
         out_imm        <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
         out_illegal    <= '0;
`endif
      end else if (flush) begin
         state     <= RUN;
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid      <= 1'b1;
         out_lane_mask  <= nxt_mask;
         out_pc         <= in_pc;
         out_reg_write  <= nxt_rw;
         out_mem_read   <= nxt_mr;
         out_mem_write  <= nxt_mw;
         out_mem_to_reg <= nxt_m2r;
         out_branch     <= nxt_br;
         out_jump       <= nxt_j;
         out_imm_sel    <= nxt_sel;
         out_imm        <= nxt_imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
         out_illegal    <= nxt_ill;
         if (|nxt_ill) state <= HALT;
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifndef DECODE_ILLEGAL_TRAP_EN
   assign out_illegal = '0;
`endif

endmodule
